// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_mp
//  Description : Multi-ported register file with two combinational read
//                ports, two write ports (port 1 wins on collisions), a
//                write-through read bypass, and a per-register pending
//                (scoreboard) bit set by a claim and cleared by a write.
//                After reset the block sweeps every register to zero, one
//                per cycle, before raising ready.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DATA_W     register / data port width in bits
//    ADDR_W     address width; DEPTH = 2**ADDR_W registers
//    ZERO_REG   1: register 0 reads as zero, is never written, never pending
//  Ports
//    clk                    single clock, all state changes on rising edge
//    rst                    synchronous active-high reset
//    rd_addr_a / rd_addr_b  read addresses
//    rd_data_a / rd_data_b  combinational read data (with write bypass)
//    rd_pend_a / rd_pend_b  registered pending bit of the addressed register
//    we_0, wa_0, wd_0       write port 0
//    we_1, wa_1, wd_1       write port 1 (priority over port 0)
//    claim_en, claim_addr   mark a register as awaiting a write
//    ready                  clear sweep done, operations accepted
// ============================================================================
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_pend_a,
    output logic              rd_pend_b,
    input  logic              we_0,
    input  logic [ADDR_W-1:0] wa_0,
    input  logic [DATA_W-1:0] wd_0,
    input  logic              we_1,
    input  logic [ADDR_W-1:0] wa_1,
    input  logic [DATA_W-1:0] wd_1,
    input  logic              claim_en,
    input  logic [ADDR_W-1:0] claim_addr,
    output logic              ready
);

    localparam int                c_DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] c_LAST_IDX = '1;
    localparam logic              c_ZERO_EN  = (ZERO_REG != 0);

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t              r_state_q;
    state_t              w_state_d;
    logic [ADDR_W-1:0]   r_clr_idx_q;
    logic [ADDR_W-1:0]   w_clr_idx_d;
    logic [DATA_W-1:0]   r_mem_q [c_DEPTH];
    logic [DATA_W-1:0]   w_mem_d [c_DEPTH];
    logic [c_DEPTH-1:0]  r_pend_q;
    logic [c_DEPTH-1:0]  w_pend_d;
    logic                w_run;
    logic                w_clearing;

    // rst is folded in so that ready and all reads drop in the same cycle
    // reset is asserted, not one edge later.
    assign w_run      = (r_state_q == S_RUN)   && !rst;
    assign w_clearing = (r_state_q == S_CLEAR) && !rst;
    assign ready      = w_run;

    // ------------------------------------------------------------------
    // Sweep FSM: CLEAR zeroes one register per cycle, leaves on the edge
    // that clears the last index.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d   = r_state_q;
        w_clr_idx_d = r_clr_idx_q;
        case (r_state_q)
            S_CLEAR: begin
                if (r_clr_idx_q == c_LAST_IDX) begin
                    w_state_d   = S_RUN;
                    w_clr_idx_d = '0;
                end else begin
                    w_clr_idx_d = r_clr_idx_q + 1'b1;
                end
            end
            S_RUN: begin
                w_state_d = S_RUN;
            end
            default: begin
                w_state_d   = S_CLEAR;
                w_clr_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= S_CLEAR;
            r_clr_idx_q <= '0;
            r_pend_q    <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_clr_idx_q <= w_clr_idx_d;
            r_pend_q    <= w_pend_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-register next-state. Register contents are not reset; the
    // sweep is what makes them zero.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < c_DEPTH; gi++) begin : g_entry
        localparam logic [ADDR_W-1:0] c_IDX       = ADDR_W'(gi);
        localparam logic              c_HARD_ZERO = c_ZERO_EN && (gi == 0);

        logic w_wr0;
        logic w_wr1;
        logic w_claim;
        logic w_sweep;

        assign w_wr0   = w_run && we_0 && (wa_0 == c_IDX);
        assign w_wr1   = w_run && we_1 && (wa_1 == c_IDX);
        assign w_claim = w_run && claim_en && (claim_addr == c_IDX);
        assign w_sweep = w_clearing && (r_clr_idx_q == c_IDX);

        // Port 1 is checked first so it wins an address collision.
        assign w_mem_d[gi] = c_HARD_ZERO ? '0    :
                             w_wr1       ? wd_1  :
                             w_wr0       ? wd_0  :
                             w_sweep     ? '0    :
                                           r_mem_q[gi];

        // A claim landing with a write leaves the register pending: the
        // claimant's write is still outstanding.
        assign w_pend_d[gi] = c_HARD_ZERO       ? 1'b0 :
                              w_claim           ? 1'b1 :
                              (w_wr0 || w_wr1)  ? 1'b0 :
                                                  r_pend_q[gi];

        always_ff @(posedge clk) begin
            r_mem_q[gi] <= w_mem_d[gi];
        end
    end

    // ------------------------------------------------------------------
    // Read ports. Data bypasses same-cycle writes; pending does not.
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] w_rd_addr [2];
    logic [DATA_W-1:0] w_rd_data [2];
    logic [1:0]        w_rd_pend;

    assign w_rd_addr[0] = rd_addr_a;
    assign w_rd_addr[1] = rd_addr_b;

    for (genvar gp = 0; gp < 2; gp++) begin : g_rd
        logic w_zero_addr;
        logic w_hit0;
        logic w_hit1;

        assign w_zero_addr = c_ZERO_EN && (w_rd_addr[gp] == '0);
        assign w_hit1      = we_1 && (wa_1 == w_rd_addr[gp]);
        assign w_hit0      = we_0 && (wa_0 == w_rd_addr[gp]);

        assign w_rd_data[gp] = (!w_run || w_zero_addr) ? '0   :
                               w_hit1                  ? wd_1 :
                               w_hit0                  ? wd_0 :
                                                         r_mem_q[w_rd_addr[gp]];

        assign w_rd_pend[gp] = (!w_run || w_zero_addr) ? 1'b0 :
                                                         r_pend_q[w_rd_addr[gp]];
    end

    assign rd_data_a = w_rd_data[0];
    assign rd_data_b = w_rd_data[1];
    assign rd_pend_a = w_rd_pend[0];
    assign rd_pend_b = w_rd_pend[1];

endmodule

`default_nettype wire
